// File: rtl/game_display_if.sv
// Game-state to display bus: the game block drives state, the display returns the panel drive.
interface game_display_if;
  logic [6:0] pile_size;
  logic [2:0] max_sub;
  logic [2:0] max_add;
  logic       plr_turn;
  logic       win;
  logic       hide;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (output pile_size, max_sub, max_add, plr_turn, win, hide,
                  input  an, seg);
  modport slave  (input  pile_size, max_sub, max_add, plr_turn, win, hide,
                  output an, seg);
endinterface

// File: rtl/game_display.sv
// 4-digit multiplexed seven-segment driver for the subtraction game: frame-coherent
// state snapshot, sequential double-dabble pile conversion, blink on win.
module game_display #(
  parameter int REFRESH_BITS = 16,
  parameter int BLINK_BITS   = 25
) (
  input logic          clk,
  input logic          rst_n,
  game_display_if.slave gd
);
  typedef enum logic {IDLE, CONV} conv_st_e;

  logic [REFRESH_BITS-1:0] dwell_q, dwell_d;
  logic [BLINK_BITS-1:0]   blink_q, blink_d;
  logic [1:0]  idx_q, idx_d;
  logic        started_q, started_d;
  logic [6:0]  sh_pile_q, sh_pile_d;
  logic [2:0]  sh_sub_q, sh_sub_d, sh_add_q, sh_add_d;
  logic        sh_plr_q, sh_plr_d, sh_win_q, sh_win_d, sh_hide_q, sh_hide_d;
  conv_st_e    st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;

  logic        wrap, frame_start;
  logic [11:0] adj, shifted;
  logic [7:0]  dig;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: glyph = 8'hC0;  4'd1: glyph = 8'hF9;  4'd2: glyph = 8'hA4;
      4'd3: glyph = 8'hB0;  4'd4: glyph = 8'h99;  4'd5: glyph = 8'h92;
      4'd6: glyph = 8'h82;  4'd7: glyph = 8'hF8;  4'd8: glyph = 8'h80;
      4'd9: glyph = 8'h90;  default: glyph = 8'hFF;
    endcase
  endfunction

  always_comb begin
    dwell_d     = dwell_q + REFRESH_BITS'(1);
    blink_d     = blink_q + BLINK_BITS'(1);
    wrap        = &dwell_q;
    frame_start = wrap && (idx_q == 2'd0);
    idx_d       = wrap ? idx_q - 2'd1 : idx_q;
    started_d   = started_q | frame_start;

    sh_pile_d = sh_pile_q;  sh_sub_d = sh_sub_q;  sh_add_d  = sh_add_q;
    sh_plr_d  = sh_plr_q;   sh_win_d = sh_win_q;  sh_hide_d = sh_hide_q;
    if (frame_start) begin
      sh_pile_d = gd.pile_size;  sh_sub_d = gd.max_sub;  sh_add_d  = gd.max_add;
      sh_plr_d  = gd.plr_turn;   sh_win_d = gd.win;      sh_hide_d = gd.hide;
    end

    // Double-dabble: add 3 to any BCD nibble >= 5, then shift in the next binary bit
    adj = bcd_q;
    for (int n = 0; n < 3; n++)
      if (bcd_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    shifted = {adj[10:0], bin_q[6]};

    st_d = st_q;  cnt_d = cnt_q;  bin_d = bin_q;  bcd_d = bcd_q;
    tens_d = tens_q;  ones_d = ones_q;
    if (frame_start) begin
      st_d  = CONV;
      cnt_d = 3'd0;
      bin_d = gd.pile_size;
      bcd_d = 12'd0;
    end else if (st_q == CONV) begin
      bcd_d = shifted;
      bin_d = {bin_q[5:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        tens_d = shifted[7:4];
        ones_d = shifted[3:0];
        st_d   = IDLE;
      end
    end

    case (idx_q)
      2'd3:    dig = sh_win_q ? 8'h8C : (glyph({1'b0, sh_sub_q}) & {~sh_plr_q, 7'h7F});
      2'd2:    dig = sh_win_q ? glyph({3'b0, sh_plr_q} + 4'd1) : glyph({1'b0, sh_add_q});
      2'd1:    dig = sh_win_q ? 8'hC0 : sh_hide_q ? 8'hBF :
                     (sh_pile_q > 7'd99) ? 8'h86 : glyph(tens_q);
      default: dig = sh_win_q ? 8'hC0 : sh_hide_q ? 8'hBF :
                     (sh_pile_q > 7'd99) ? 8'h86 : glyph(ones_q);
    endcase

    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (started_q && !(sh_win_q && blink_q[BLINK_BITS-1])) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;  blink_q <= '0;  idx_q <= 2'd0;  started_q <= 1'b0;
      sh_pile_q <= '0;  sh_sub_q <= '0;  sh_add_q  <= '0;
      sh_plr_q  <= 1'b0; sh_win_q <= 1'b0; sh_hide_q <= 1'b0;
      st_q <= IDLE;  cnt_q <= '0;  bin_q <= '0;  bcd_q <= '0;
      tens_q <= '0;  ones_q <= '0;
      an_q <= 4'b1111;  seg_q <= 8'hFF;
    end else begin
      dwell_q <= dwell_d;  blink_q <= blink_d;  idx_q <= idx_d;  started_q <= started_d;
      sh_pile_q <= sh_pile_d;  sh_sub_q <= sh_sub_d;  sh_add_q  <= sh_add_d;
      sh_plr_q  <= sh_plr_d;   sh_win_q <= sh_win_d;  sh_hide_q <= sh_hide_d;
      st_q <= st_d;  cnt_q <= cnt_d;  bin_q <= bin_d;  bcd_q <= bcd_d;
      tens_q <= tens_d;  ones_q <= ones_d;
      an_q <= an_d;  seg_q <= seg_d;
    end
  end

  assign gd.an  = an_q;
  assign gd.seg = seg_q;
endmodule

// File: tb/tb_game_display.sv
// Bench for game_display: cycle-by-cycle comparison against a frame/blink arithmetic
// model, plus hand-computed anode/segment checks at chosen cycles.
module tb_game_display;
  localparam int RB = 4;
  localparam int BB = 6;
  localparam int P  = 1 << RB;

  typedef struct packed {
    logic [6:0] pile;
    logic [2:0] sub;
    logic [2:0] add;
    logic       plr;
    logic       win;
    logic       hide;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_display_if gd();
  game_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (.clk(clk), .rst_n(rst_n), .gd(gd));

  int    k;
  snap_t snap_now, snap_vis;
  int    tests = 0;
  int    fails = 0;

  // Model: k counts clock edges since reset release; the snapshot is taken on each
  // frame-start edge and becomes visible on the output one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= 0;
      snap_now <= '0;
      snap_vis <= '0;
    end else begin
      k        <= k + 1;
      snap_vis <= snap_now;
      if (((k + 1) % (4 * P)) == P)
        snap_now <= {gd.pile_size, gd.max_sub, gd.max_add, gd.plr_turn, gd.win, gd.hide};
    end
  end

  function automatic logic [7:0] g(input int v);
    case (v)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [11:0] expect_out(input int kk, input snap_t s);
    int j, idx, pile;
    logic [3:0] a;
    logic [7:0] sg;
    if (kk <= P) return {4'hF, 8'hFF};
    j   = kk - 1;
    idx = (4 - ((j / P) % 4)) % 4;
    if (s.win && (((j >> (BB - 1)) & 1) == 1)) return {4'hF, 8'hFF};
    pile = int'(s.pile);
    if (s.win) begin
      case (idx)
        3: sg = 8'h8C;
        2: sg = g(int'(s.plr) + 1);
        default: sg = 8'hC0;
      endcase
    end else begin
      case (idx)
        3: sg = s.plr ? (g(int'(s.sub)) & 8'h7F) : g(int'(s.sub));
        2: sg = g(int'(s.add));
        1: sg = s.hide ? 8'hBF : (pile > 99) ? 8'h86 : g(pile / 10);
        default: sg = s.hide ? 8'hBF : (pile > 99) ? 8'h86 : g(pile % 10);
      endcase
    end
    a = 4'hF;
    a[idx] = 1'b0;
    return {a, sg};
  endfunction

  always @(negedge clk) begin
    logic [11:0] e;
    e = expect_out(k, snap_vis);
    tests++;
    if ({gd.an, gd.seg} !== e) begin
      fails++;
      $display("FAIL model k=%0d: an=%b seg=%h, expected an=%b seg=%h",
               k, gd.an, gd.seg, e[11:8], e[7:0]);
    end
  end

  task automatic lit(input string nm, input logic [3:0] ea, input logic [7:0] es);
    tests++;
    if (gd.an !== ea || gd.seg !== es) begin
      fails++;
      $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", nm, gd.an, gd.seg, ea, es);
    end
  endtask

  task automatic go(input int n);
    int guard = 0;
    while (k != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (k != n) begin
      tests++;
      fails++;
      $display("FAIL timeout: k=%0d, expected %0d", k, n);
    end
  endtask

  initial begin
    gd.pile_size = 7'd73; gd.max_sub = 3'd4; gd.max_add = 3'd2;
    gd.plr_turn = 1'b0; gd.win = 1'b0; gd.hide = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 4'b1111, 8'hFF);
    rst_n = 1'b1;

    go(16);  lit("pre_frame", 4'b1111, 8'hFF);
    go(17);  lit("d3_sub4",   4'b0111, 8'h99);
    go(33);  lit("d2_add2",   4'b1011, 8'hA4);
    go(40);  gd.pile_size = 7'd8;
    go(49);  lit("tens7_held", 4'b1101, 8'hF8);
    go(65);  lit("ones3_held", 4'b1110, 8'hB0);
    go(113); lit("tens0",      4'b1101, 8'hC0);
    go(129); lit("ones8",      4'b1110, 8'h80);

    go(130); gd.hide = 1'b1; gd.plr_turn = 1'b1; gd.pile_size = 7'd45;
    go(145); lit("d3_dp",      4'b0111, 8'h19);
    go(177); lit("hide_tens",  4'b1101, 8'hBF);
    go(193); lit("hide_ones",  4'b1110, 8'hBF);

    go(200); gd.hide = 1'b0; gd.plr_turn = 1'b0; gd.pile_size = 7'd99;
    go(241); lit("p99_tens",   4'b1101, 8'h90);
    go(257); lit("p99_ones",   4'b1110, 8'h90);
    go(260); gd.pile_size = 7'd100;
    go(305); lit("p100_tens",  4'b1101, 8'h86);
    go(321); lit("p100_ones",  4'b1110, 8'h86);
    go(322); gd.pile_size = 7'd0;
    go(369); lit("p0_tens",    4'b1101, 8'hC0);
    go(385); lit("p0_ones",    4'b1110, 8'hC0);

    go(390); gd.win = 1'b1; gd.plr_turn = 1'b1;
    go(401); lit("win_P",      4'b0111, 8'h8C);
    go(417); lit("win_blink2", 4'b1111, 8'hFF);
    go(433); lit("win_blink1", 4'b1111, 8'hFF);
    go(449); lit("win_d0",     4'b1110, 8'hC0);
    go(465); lit("win_P2",     4'b0111, 8'h8C);

    go(470); gd.win = 1'b0; gd.plr_turn = 1'b0; gd.pile_size = 7'd57;
             gd.max_sub = 3'd3; gd.max_add = 3'd1;
    go(531); lit("d3_pre_rst", 4'b0111, 8'hB0);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 4'b1111, 8'hFF);
    gd.pile_size = 7'd61;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(16);  lit("rst_pre_frame", 4'b1111, 8'hFF);
    go(17);  lit("rst_d3",     4'b0111, 8'hB0);
    go(33);  lit("rst_d2",     4'b1011, 8'hF9);
    go(49);  lit("rst_tens6",  4'b1101, 8'h82);
    go(65);  lit("rst_ones1",  4'b1110, 8'hF9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_display.md
Name: game_display

Overview:
- Downstream display stage for the subtraction game.
- Consumes the game state outputs (pile_size, max_sub, max_add, plr_turn, win, hide) and drives a 4-digit multiplexed seven-segment display.
- Snapshots game state once per scan frame so digits never tear mid-frame.
- Converts pile_size to BCD with a sequential double-dabble engine; blinks the display on a win.

Parameters:
- REFRESH_BITS, 16, width of the per-digit dwell counter; each digit is shown for 2^REFRESH_BITS clocks. Must be >= 4.
- BLINK_BITS, 25, width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clk  input  1  system clock (fast board clock).
- rst_n  input  1  asynchronous, active-low reset.
- pile_size  input  7  current pile size from the game block.
- max_sub  input  3  maximum subtract amount.
- max_add  input  3  maximum add amount.
- plr_turn  input  1  0 = player 1, 1 = player 2. Holds the winner when win=1.
- win  input  1  game-over flag.
- hide  input  1  last move was hidden.
- an  output  4  digit anodes, active-low; an[3] is the leftmost digit.
- seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=gfedcba.

Behaviour:
- Reset (async, rst_n=0):
  - an=4'b1111, seg=8'hFF.
  - Dwell counter, blink counter, digit index and converter state all 0; shadow registers cleared; started=0.
- Scan sequencing:
  - The dwell counter increments every clock.
  - When it equals all-ones, the digit index steps 0->3->2->1->0 (down-counting, wraps).
  - The 0->3 step is the frame start.
  - an/seg are registered and reflect the index one clock after it changes.
  - Until the first frame start (started=0), an stays 4'b1111.
- Snapshot: on the frame-start edge, all six inputs are captured into shadow registers and the converter starts. Input changes at any other time do not affect the display until the next frame start.
- BCD converter:
  - States IDLE and CONV. Shifts shadow pile_size through double-dabble for exactly 7 cycles (add 3 to any nibble >= 5 before each shift).
  - On the 7th cycle it writes the tens/ones registers and returns to IDLE.
  - Display uses the last completed result. The converter is guaranteed done before digit 1 is shown.
  - Shadow pile_size > 99 displays 'E','E' instead of the converted value.
- Digit content, normal mode (shadow win=0):
  - digit3 = max_sub; dp lit (seg[7]=0) when shadow plr_turn=1.
  - digit2 = max_add.
  - digit1 = tens; digit0 = ones. Leading zero is shown.
  - If shadow hide=1, digit1 and digit0 show dash instead of the pile value.
- Digit content, win mode (shadow win=1):
  - digit3 = 'P', digit2 = player number (shadow plr_turn+1), digit1 = 0, digit0 = 0. dp off.
  - While blink phase (blink MSB) = 1, an is forced to 4'b1111 and seg=8'hFF.
  - Scanning continues regardless of blink.
- Glyph encodings, seg[7:0], dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - dash=BF, P=8C, E=86, blank=FF.
  - With dp lit, bit 7 is cleared.
- Exactly one an bit is low whenever the display is active. The digit with an low receives its matching seg in the same cycle.
- Reset asserted mid-frame or mid-conversion:
  - Outputs go blank immediately; the conversion is abandoned.
  - After release, the display stays blank until the next frame start.

Test Plan:
1. REFRESH_BITS=4: release reset with inputs pile=73, sub=4, add=2, plr=0, win=0, hide=0 -> an blank for 16 clocks. Then an sequence 0111,1011,1101,1110 (16 clocks each) with seg 99, A4, F8, B0.
2. Mid-frame, change pile 73->8 while digit2 is active -> current frame still shows 7,3. Next frame shows 0,8 (C0, 80).
3. hide=1, plr_turn=1, pile=45 -> digit3 seg has bit 7 = 0. digit1 and digit0 show BF, BF.
4. win=1, plr_turn=1, BLINK_BITS=6 -> digits show 8C, A4, C0, C0 while blink MSB=0. an=1111 for the 32 clocks the MSB=1, alternating.
5. pile=99 -> 90, 90. pile=100 -> 86, 86. pile=0 -> C0, C0.
6. Assert rst_n=0 during CONV cycle 3 -> an=1111 and seg=FF asynchronously. After release, no digit is driven before the first dwell wrap, and the converted value matches the fresh snapshot.
